// File: rtl/clock_div_monitor_if.sv
// Bundles the divided-clock input, the monitor enable and all measurement and
// status outputs of clock_div_monitor. The monitor connects through the slave
// modport; whatever drives div_in/enable and consumes status uses master.
interface clock_div_monitor_if #(
    parameter int CW = 8
);
    logic          enable;
    logic          div_in;
    logic          meas_valid;
    logic [CW-1:0] period_meas;
    logic [CW-1:0] high_meas;
    logic          period_err;
    logic          duty_err;
    logic          locked;
    logic [7:0]    err_count;

    // Stimulus / consumer side.
    modport master (
        output enable,
        output div_in,
        input  meas_valid,
        input  period_meas,
        input  high_meas,
        input  period_err,
        input  duty_err,
        input  locked,
        input  err_count
    );

    // Monitor side.
    modport slave (
        input  enable,
        input  div_in,
        output meas_valid,
        output period_meas,
        output high_meas,
        output period_err,
        output duty_err,
        output locked,
        output err_count
    );
endinterface

// File: rtl/clock_div_monitor.sv
// Measures the period and high phase of a divided clock in clk_in cycles and
// flags period errors, duty errors and a stuck input. After LOCK_CNT
// consecutive good periods, locked is raised. Every output is registered.
// div_in is generated from clk_in, so a plain two-flop sampler is enough to
// find edges. No synchronizer is needed.
module clock_div_monitor #(
    parameter int DIV      = 5,
    parameter int CW       = 8,
    parameter int LOCK_CNT = 4
) (
    input  logic                clk_in,
    input  logic                rst,
    clock_div_monitor_if.slave  mon
);

    // Reject parameter sets where the counters could wrap before the stuck
    // limit is reached.
    generate
        if (DIV < 2) begin : g_div_too_small
            $error("clock_div_monitor: DIV must be at least 2");
        end
        if (4 * DIV >= (1 << CW)) begin : g_cw_too_narrow
            $error("clock_div_monitor: 4*DIV must fit in CW bits");
        end
        if (LOCK_CNT < 1) begin : g_lock_cnt_too_small
            $error("clock_div_monitor: LOCK_CNT must be at least 1");
        end
    endgenerate

    localparam int SW = $clog2(LOCK_CNT + 1);

    localparam logic [CW-1:0] DIV_C     = CW'(DIV);
    localparam logic [CW-1:0] HALF_LO_C = CW'(DIV / 2);
    localparam logic [CW-1:0] HALF_HI_C = CW'((DIV + 1) / 2);
    localparam logic [CW-1:0] STUCK_C   = CW'(4 * DIV);
    localparam logic [CW-1:0] ONE_C     = CW'(1);
    localparam logic [SW-1:0] LOCK_C    = SW'(LOCK_CNT);
    localparam logic [SW-1:0] STREAK1_C = SW'(1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_RISE = 2'd1,
        S_RUN       = 2'd2
    } state_t;

    // Input sampler
    logic div_q;
    logic div_qq;
    logic rise;

    // FSM and measurement counters
    state_t        state_q,  state_d;
    logic [CW-1:0] hi_cnt_q, hi_cnt_d;
    logic [CW-1:0] lo_cnt_q, lo_cnt_d;
    logic [SW-1:0] streak_q, streak_d;

    // Registered outputs
    logic          meas_valid_q,  meas_valid_d;
    logic [CW-1:0] period_meas_q, period_meas_d;
    logic [CW-1:0] high_meas_q,   high_meas_d;
    logic          period_err_q,  period_err_d;
    logic          duty_err_q,    duty_err_d;
    logic          locked_q,      locked_d;
    logic [7:0]    err_count_q,   err_count_d;

    // Helpers for the current period
    logic [CW-1:0] sum_cnt;
    logic          period_bad;
    logic          duty_bad;
    logic [7:0]    err_count_inc;

    assign rise          = div_q & ~div_qq;
    assign sum_cnt       = hi_cnt_q + lo_cnt_q;
    assign period_bad    = (sum_cnt != DIV_C);
    assign duty_bad      = (hi_cnt_q != HALF_LO_C) && (hi_cnt_q != HALF_HI_C);
    assign err_count_inc = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;

    // Two-flop sampling of the divided clock for edge detection.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            div_q  <= 1'b0;
            div_qq <= 1'b0;
        end else begin
            div_q  <= mon.div_in;
            div_qq <= div_q;
        end
    end

    // FSM state and measurement counters.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            hi_cnt_q <= '0;
            lo_cnt_q <= '0;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            hi_cnt_q <= hi_cnt_d;
            lo_cnt_q <= lo_cnt_d;
            streak_q <= streak_d;
        end
    end

    // Registered measurement and status outputs.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            meas_valid_q  <= 1'b0;
            period_meas_q <= '0;
            high_meas_q   <= '0;
            period_err_q  <= 1'b0;
            duty_err_q    <= 1'b0;
            locked_q      <= 1'b0;
            err_count_q   <= '0;
        end else begin
            meas_valid_q  <= meas_valid_d;
            period_meas_q <= period_meas_d;
            high_meas_q   <= high_meas_d;
            period_err_q  <= period_err_d;
            duty_err_q    <= duty_err_d;
            locked_q      <= locked_d;
            err_count_q   <= err_count_d;
        end
    end

    // Next state: edge tracking, period completion, checks, stuck detection.
    always_comb begin
        state_d       = state_q;
        hi_cnt_d      = hi_cnt_q;
        lo_cnt_d      = lo_cnt_q;
        streak_d      = streak_q;
        meas_valid_d  = 1'b0;
        period_meas_d = period_meas_q;
        high_meas_d   = high_meas_q;
        period_err_d  = 1'b0;
        duty_err_d    = 1'b0;
        err_count_d   = err_count_q;

        if (!mon.enable) begin
            // Disable beats everything, including a simultaneous rise. The
            // partial period is dropped and the held measurements stay.
            state_d  = S_IDLE;
            hi_cnt_d = '0;
            lo_cnt_d = '0;
            streak_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    hi_cnt_d = '0;
                    lo_cnt_d = '0;
                    streak_d = '0;
                    state_d  = S_WAIT_RISE;
                end

                S_WAIT_RISE: begin
                    // The first edge only anchors the count. Nothing has
                    // been measured yet.
                    if (rise) begin
                        hi_cnt_d = ONE_C;
                        lo_cnt_d = '0;
                        state_d  = S_RUN;
                    end
                end

                S_RUN: begin
                    if (rise) begin
                        meas_valid_d  = 1'b1;
                        period_meas_d = sum_cnt;
                        high_meas_d   = hi_cnt_q;
                        period_err_d  = period_bad;
                        duty_err_d    = duty_bad;
                        if (period_bad || duty_bad) begin
                            // Both flags together count as one event.
                            err_count_d = err_count_inc;
                            streak_d    = '0;
                        end else if (streak_q != LOCK_C) begin
                            streak_d = streak_q + STREAK1_C;
                        end
                        // The rising sample opens the next period's high phase.
                        hi_cnt_d = ONE_C;
                        lo_cnt_d = '0;
                    end else if (sum_cnt >= STUCK_C) begin
                        // No edge within 4*DIV samples: report the limit as
                        // the period and wait for the input to come back.
                        period_err_d  = 1'b1;
                        period_meas_d = STUCK_C;
                        err_count_d   = err_count_inc;
                        streak_d      = '0;
                        hi_cnt_d      = '0;
                        lo_cnt_d      = '0;
                        state_d       = S_WAIT_RISE;
                    end else if (div_q) begin
                        hi_cnt_d = hi_cnt_q + ONE_C;
                    end else begin
                        lo_cnt_d = lo_cnt_q + ONE_C;
                    end
                end

                default: begin
                    state_d  = S_IDLE;
                    hi_cnt_d = '0;
                    lo_cnt_d = '0;
                    streak_d = '0;
                end
            endcase
        end

        // locked follows the streak on the same edge, so it rises with the
        // LOCK_CNT-th good measurement and drops with the first error.
        locked_d = (streak_d == LOCK_C);
    end

    assign mon.meas_valid  = meas_valid_q;
    assign mon.period_meas = period_meas_q;
    assign mon.high_meas   = high_meas_q;
    assign mon.period_err  = period_err_q;
    assign mon.duty_err    = duty_err_q;
    assign mon.locked      = locked_q;
    assign mon.err_count   = err_count_q;

endmodule

// File: tb/tb_clock_div_monitor.sv
// Directed bench for clock_div_monitor. Each driven period pushes the
// measurement it completes onto a scoreboard queue. A negedge monitor pops
// and compares an entry whenever the monitor pulses meas_valid or an error
// flag, and it also checks the cycle on which the pulse appears.
module tb_clock_div_monitor;

    localparam int DIV      = 5;
    localparam int CW       = 8;
    localparam int LOCK_CNT = 4;
    localparam int STUCK    = 4 * DIV;

    logic clk_in = 1'b0;
    logic rst    = 1'b0;
    int   cyc    = 0;

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    clock_div_monitor_if #(.CW(CW)) bus ();

    clock_div_monitor #(
        .DIV      (DIV),
        .CW       (CW),
        .LOCK_CNT (LOCK_CNT)
    ) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .mon    (bus.slave)
    );

    typedef struct {
        logic          valid;
        logic [CW-1:0] period;
        logic [CW-1:0] high;
        logic          perr;
        logic          derr;
        logic          locked;
        logic [7:0]    errs;
        int            at_cyc;
    } exp_t;

    exp_t sb[$];

    int tests_run    = 0;
    int tests_failed = 0;

    // Behavioural expectations
    int            m_streak      = 0;
    int            m_errs        = 0;
    logic [CW-1:0] m_high_hold   = '0;
    logic [CW-1:0] m_period_hold = '0;
    bit            have_prev     = 1'b0;
    int            prev_h        = 0;
    int            prev_l        = 0;
    int            last_rise_cyc = 0;

    function automatic void check(string tag, logic [31:0] obs, logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endfunction

    function automatic void model_reset();
        m_streak      = 0;
        m_errs        = 0;
        m_high_hold   = '0;
        m_period_hold = '0;
        have_prev     = 1'b0;
        sb.delete();
    endfunction

    // Expected result of a completed h-high/l-low period, issued by the rise
    // driven at cycle `rise_cyc`.
    function automatic void push_meas(int h, int l, int rise_cyc);
        exp_t e;
        bit   pb, db;
        pb = (h + l) != DIV;
        db = (h != DIV / 2) && (h != (DIV + 1) / 2);
        if (pb || db) begin
            if (m_errs < 255) m_errs++;
            m_streak = 0;
        end else if (m_streak < LOCK_CNT) begin
            m_streak++;
        end
        m_high_hold   = CW'(h);
        m_period_hold = CW'(h + l);
        e.valid  = 1'b1;
        e.period = CW'(h + l);
        e.high   = CW'(h);
        e.perr   = pb;
        e.derr   = db;
        e.locked = (m_streak == LOCK_CNT);
        e.errs   = 8'(m_errs);
        e.at_cyc = rise_cyc + 2;
        sb.push_back(e);
    endfunction

    task automatic tick(int n = 1);
        repeat (n) @(negedge clk_in);
    endtask

    // One period of div_in. Called and returns on a negedge with div_in low.
    task automatic drive_period(int h, int l);
        if (have_prev) push_meas(prev_h, prev_l, cyc);
        last_rise_cyc = cyc;
        have_prev     = 1'b1;
        prev_h        = h;
        prev_l        = l;
        bus.div_in = 1'b1;
        tick(h);
        bus.div_in = 1'b0;
        tick(l);
    endtask

    // Hold div_in low long enough to trip the stuck detector.
    task automatic drive_stuck(int n);
        exp_t e;
        if (m_errs < 255) m_errs++;
        m_streak      = 0;
        m_period_hold = CW'(STUCK);
        e.valid  = 1'b0;
        e.period = CW'(STUCK);
        e.high   = m_high_hold;
        e.perr   = 1'b1;
        e.derr   = 1'b0;
        e.locked = 1'b0;
        e.errs   = 8'(m_errs);
        e.at_cyc = last_rise_cyc + STUCK + 2;
        sb.push_back(e);
        have_prev  = 1'b0;
        bus.div_in = 1'b0;
        tick(n);
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_meas_valid"},  bus.meas_valid,  0);
        check({tag, "_period_meas"}, bus.period_meas, 0);
        check({tag, "_high_meas"},   bus.high_meas,   0);
        check({tag, "_period_err"},  bus.period_err,  0);
        check({tag, "_duty_err"},    bus.duty_err,    0);
        check({tag, "_locked"},      bus.locked,      0);
        check({tag, "_err_count"},   bus.err_count,   0);
    endtask

    // Scoreboard consumer: one line per completed transaction.
    always @(negedge clk_in) begin
        if (!rst && (bus.meas_valid || bus.period_err || bus.duty_err)) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse",
                      {29'd0, bus.meas_valid, bus.period_err, bus.duty_err}, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("[TB] cyc=%0d valid=%0b period=%0d high=%0d perr=%0b derr=%0b locked=%0b errs=%0d",
                         cyc, bus.meas_valid, bus.period_meas, bus.high_meas,
                         bus.period_err, bus.duty_err, bus.locked, bus.err_count);
                check("pulse_cycle", cyc,             e.at_cyc);
                check("meas_valid",  bus.meas_valid,  e.valid);
                check("period_meas", bus.period_meas, e.period);
                check("high_meas",   bus.high_meas,   e.high);
                check("period_err",  bus.period_err,  e.perr);
                check("duty_err",    bus.duty_err,    e.derr);
                check("locked",      bus.locked,      e.locked);
                check("err_count",   bus.err_count,   e.errs);
            end
        end
    end

    initial begin
        bus.enable = 1'b0;
        bus.div_in = 1'b0;

        // Reset state, before the first clock edge.
        #1 rst = 1'b1;
        #1 check_all_zero("reset");
        tick(2);
        rst = 1'b0;
        tick();
        bus.enable = 1'b1;
        tick(3);

        // Clean divide-by-5, mixing 3/2 and 2/3 splits.
        for (int i = 0; i < 8; i++) drive_period((i % 3 == 2) ? 2 : 3, (i % 3 == 2) ? 3 : 2);
        check("clean_locked",    bus.locked,    (m_streak == LOCK_CNT) ? 1 : 0);
        check("clean_err_count", bus.err_count, m_errs);

        // Wrong period for three periods, then recovery.
        for (int i = 0; i < 3; i++) drive_period(3, 3);
        check("div6_unlocked", bus.locked, 0);
        for (int i = 0; i < 6; i++) drive_period(3, 2);
        check("div6_err_count", bus.err_count, m_errs);
        check("div6_relocked",  bus.locked,    (m_streak == LOCK_CNT) ? 1 : 0);

        // Bad duty: correct period, single high sample.
        for (int i = 0; i < 4; i++) drive_period(1, 4);
        check("duty_locked", bus.locked, 0);
        for (int i = 0; i < 6; i++) drive_period(3, 2);
        check("duty_err_count", bus.err_count, m_errs);
        check("duty_relocked",  bus.locked,    (m_streak == LOCK_CNT) ? 1 : 0);

        // Stuck low while locked. The rise after recovery must not measure.
        drive_stuck(30);
        check("stuck_locked",      bus.locked,      0);
        check("stuck_period_meas", bus.period_meas, STUCK);
        for (int i = 0; i < 6; i++) drive_period(3, 2);

        // Drop enable two cycles into a period.
        push_meas(prev_h, prev_l, cyc);
        have_prev  = 1'b0;
        bus.div_in = 1'b1;
        tick(2);
        bus.enable = 1'b0;
        tick();
        m_streak = 0;
        check("disable_locked",      bus.locked,      0);
        check("disable_err_count",   bus.err_count,   m_errs);
        check("disable_period_meas", bus.period_meas, m_period_hold);
        tick(3);
        bus.div_in = 1'b0;
        tick(3);
        bus.enable = 1'b1;
        tick(3);
        for (int i = 0; i < 5; i++) drive_period(3, 2);

        // Asynchronous reset mid-period.
        push_meas(prev_h, prev_l, cyc);
        bus.div_in = 1'b1;
        tick(2);
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        model_reset();
        bus.div_in = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(3);

        // Saturation of the error counter.
        drive_period(3, 2);
        for (int i = 0; i < 260; i++) drive_period(1, 4);
        check("sat_err_count", bus.err_count, 255);
        check("sat_locked",    bus.locked,    0);
        tick(3);
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/clock_div_monitor.md
# clock_div_monitor

Checks the divided clock produced by the divide-by-N stage (the 50 % duty divide-by-5 output) in the source clock domain. The block samples the divided clock on `clk_in`, measures every period and high phase in `clk_in` cycles, and flags period or duty errors. After a run of good periods it asserts `locked`. It sits directly downstream of the divider and feeds status LEDs and the bench scoreboard.

## Interface
- `DIV`, 5: expected divide ratio in `clk_in` cycles. Legal range is 2 ≤ DIV and 4·DIV < 2^CW.
- `CW`, 8: width of the measurement counters and outputs.
- `LOCK_CNT`, 4: number of consecutive good periods required before `locked` asserts.

- `clk_in`  in  1  source clock; the only clock in the block.
- `rst`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  monitor enable. Low forces IDLE.
- `div_in`  in  1  divided clock under test.
- `meas_valid`  out  1  one-cycle pulse when a period measurement completes.
- `period_meas`  out  CW  last measured period, in cycles.
- `high_meas`  out  CW  last measured high-phase sample count.
- `period_err`  out  1  one-cycle pulse: bad period or stuck input.
- `duty_err`  out  1  one-cycle pulse: bad high/low split.
- `locked`  out  1  level: LOCK_CNT consecutive good periods seen.
- `err_count`  out  8  total error events, saturating at 255.

## Operation
- **Input sampling**
  - `div_q` ← `div_in` and `div_qq` ← `div_q` on every `clk_in` posedge.
  - `rise` = `div_q & ~div_qq`.
  - There is no further synchronizer, because `div_in` is derived from `clk_in`.
- **FSM states**
  - IDLE: entered when `enable`=0; clears `hi_cnt`, `lo_cnt` and `streak`; `locked`=0. Goes to WAIT_RISE when `enable`=1.
  - WAIT_RISE: on `rise`, loads `hi_cnt`=1, `lo_cnt`=0 and goes to RUN. No measurement is issued for this first edge.
  - RUN, non-`rise` cycle: `hi_cnt`++ if `div_q`=1, otherwise `lo_cnt`++.
  - RUN, `rise` cycle: completes the period.
    - `period_meas` = `hi_cnt`+`lo_cnt`, `high_meas` = `hi_cnt`, `meas_valid`=1.
    - Reloads `hi_cnt`=1, `lo_cnt`=0 and stays in RUN.
- **Checks on each completed period**
  - `period_err` if `period_meas` ≠ DIV.
  - `duty_err` if `high_meas` is not in {⌊DIV/2⌋, ⌈DIV/2⌉}.
  - Both flags may pulse in the same cycle. That counts as a single error event for `err_count`.
- **Lock logic**
  - A good period (no error) increments `streak`, saturating at LOCK_CNT.
  - `locked` = (`streak` == LOCK_CNT).
  - Any error clears `streak` to 0 and `locked` to 0 in the same cycle.
- **Stuck detection (RUN only)**
  - Triggers if `hi_cnt`+`lo_cnt` reaches 4·DIV without a `rise`.
  - Response: `period_err` pulse, `meas_valid`=0, `period_meas` = 4·DIV, `err_count`++, `streak`=0, return to WAIT_RISE.
- **Enable deassertion mid-period:** go to IDLE on the next edge. The partial period is discarded with no pulses. `period_meas`, `high_meas` and `err_count` hold their values.
- **`err_count`:** +1 per error event and saturates at 255. Cleared only by `rst`.
- **Arithmetic:** all counters are CW bits unsigned. The stuck limit guarantees they never wrap.

## Timing
- `rst` asserted: every output goes to 0 immediately, the FSM goes to IDLE, and `div_q`/`div_qq` are cleared.
- Release of `rst` is sampled on the next posedge.
- **Latency:** if `div_in` is first sampled high at posedge N (`div_q`=1 after N), `rise` is seen in cycle N+1. `meas_valid` and the error flags are registered at posedge N+1 and stay high for exactly one cycle. `period_meas`, `high_meas`, `locked` and `err_count` update on that same edge.
- **Expected values for a correct 50 % divide-by-5 input sampled on posedge:** period 5, high 3 (or 2), one `meas_valid` every 5 cycles.
- **Simultaneous events**
  - `enable` falling in the same cycle as `rise`: IDLE wins; no measurement.
  - `rst` is asynchronous and overrides everything.
- **Lock timing:** `locked` rises on the edge that issues the LOCK_CNT-th consecutive good `meas_valid`. It falls on the edge that issues the error.

## Test plan
- **Clean divide-by-5 input.** Connect `div_in` to a correct 50 % divide-by-5, `enable`=1 after reset.
  - `meas_valid` every 5 cycles with `period_meas`=5 and `high_meas` of 3 or 2.
  - `locked`=1 on the 4th measurement.
  - `err_count`=0.
- **Wrong period, then recovery.** Drive `div_in` with a divide-by-6 waveform for 3 periods, then divide-by-5.
  - Three `period_err` pulses with `period_meas`=6, so `err_count`=3.
  - `locked` returns to 1 four good periods later.
- **Bad duty.** Drive period 5 with 1 high sample.
  - `duty_err` pulses with `period_err`=0 and `high_meas`=1.
  - `err_count` increments once per period.
  - `locked` stays 0.
- **Stuck input.** Hold `div_in`=0 for 30 cycles while locked.
  - One `period_err` pulse 20 cycles after the last `rise`, with `period_meas`=20.
  - `locked`=0 and the FSM is in WAIT_RISE.
  - The next `rise` issues no `meas_valid`.
- **Enable and reset mid-operation.**
  - Drop `enable` 2 cycles into a period: no pulses, `locked`=0, `err_count` held.
  - Assert `rst` asynchronously mid-period: all outputs are 0 before the next posedge.
- **Saturation.** Inject 260 bad periods: `err_count` stays at 255 and never wraps to 0.
